pipe_hazard_ctrl: RTL

Parametrised pipeline hazard and stall controller for the 5-stage RV32 core. It sits beside the datapath and drives per-stage enables (valid_*) and flushes (flash_*). It covers load-use stalls with x0 exclusion and branch flushes with branch priority. It also covers variable-latency data-memory stalls, either from a fixed latency counter or from a mem_ready handshake. Two saturating performance counters record stall cycles.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: M-stage wait FSM encoding
// and the default build parameters used by the core.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  localparam int LOAD_LAT_DEF      = 0;
  localparam int USE_MEM_READY_DEF = 0;
  localparam int REG_AW_DEF        = 5;
  localparam int CNT_W_DEF         = 4;
  localparam int PERF_W_DEF        = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall performance counters; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != '1)) begin
      q_d = q_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / branch / data-memory hazard controller for the 5-stage RV32 pipeline.
// Drives per-stage advance enables and bubble-insert flushes, plus stall perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_LAT      = LOAD_LAT_DEF,
  parameter int USE_MEM_READY = USE_MEM_READY_DEF,
  parameter int REG_AW        = REG_AW_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int PERF_W        = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              regwrite_e,
  input  logic              memread_e,
  input  logic              memread_m,
  input  logic              pcsrc_e,
  input  logic              mem_ready,
  output logic              valid_PC,
  output logic              valid_F,
  output logic              valid_D,
  output logic              valid_E,
  output logic              valid_M,
  output logic              flash_D,
  output logic              flash_E,
  output logic              flash_W,
  output logic              mem_busy,
  output logic [PERF_W-1:0] lwstall_cnt,
  output logic [PERF_W-1:0] memstall_cnt
);

  if ((USE_MEM_READY == 0) && (CNT_W < 32) && (LOAD_LAT > (2 ** CNT_W) - 1)) begin : g_bad_cfg
    $error("CNT_W too narrow for LOAD_LAT");
  end

  mem_state_e         state_q;
  mem_state_e         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               mem_busy_q;

  logic               lwstall;
  logic               lwstall_eff;
  logic               mem_stall_raw;
  logic               mem_stall;

  assign lwstall = memread_e & regwrite_e & (rd_e != '0) &
                   ((rs1_d == rd_e) | (rs2_d == rd_e));
  // A taken branch squashes the dependent instruction in D, so no stall is needed.
  assign lwstall_eff = lwstall & ~pcsrc_e;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_stall_raw = 1'b0;
    if (USE_MEM_READY != 0) begin
      case (state_q)
        ST_IDLE: begin
          if (memread_m && !mem_ready) begin
            mem_stall_raw = 1'b1;
            state_d       = ST_WAIT;
          end
        end
        ST_WAIT: begin
          mem_stall_raw = ~mem_ready;
          if (mem_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (LOAD_LAT > 0) begin
      case (state_q)
        ST_IDLE: begin
          if (memread_m) begin
            mem_stall_raw = 1'b1;
            state_d       = ST_WAIT;
            cnt_d         = CNT_W'(LOAD_LAT - 1);
          end
        end
        ST_WAIT: begin
          if (cnt_q != '0) begin
            mem_stall_raw = 1'b1;
            cnt_d         = cnt_q - 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Reset must release the pipeline at once, even while memread_m is still high.
  assign mem_stall = mem_stall_raw & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mem_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_busy_q <= (state_d == ST_WAIT);
    end
  end

  assign valid_PC = ~(mem_stall | lwstall_eff);
  assign valid_F  = ~(mem_stall | lwstall_eff);
  assign valid_D  = ~mem_stall;
  assign valid_E  = ~mem_stall;
  assign valid_M  = ~mem_stall;
  assign flash_D  = pcsrc_e & ~mem_stall;
  assign flash_E  = (pcsrc_e | lwstall_eff) & ~mem_stall;
  assign flash_W  = mem_stall;
  assign mem_busy = mem_busy_q;

  sat_counter #(.W(PERF_W)) u_lwstall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (lwstall_eff & ~mem_stall),
    .q   (lwstall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_memstall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mem_stall),
    .q   (memstall_cnt)
  );

endmodule
